// File: rtl/perceptron_trainer_if.sv
// Valid/ready channels between the trainer (master) and one perceptron (slave).
// Four channels: argument out, result back, error out, propagate back.
interface perceptron_trainer_if #(
  parameter int N = 2,
  parameter int W = 8
);
  logic                        train;
  logic                        argument_valid;
  logic                        argument_ready;
  logic [N-1:0][W-1:0]         argument_data;
  logic                        result_valid;
  logic                        result_ready;
  logic [W-1:0]                result_data;
  logic                        error_valid;
  logic                        error_ready;
  logic [2*W-1:0]              error_data;
  logic                        propagate_valid;
  logic                        propagate_ready;
  logic [N-1:0][2*W-1:0]       propagate_data;

  modport master (
    output train,
    output argument_valid, argument_data,
    input  argument_ready,
    input  result_valid, result_data,
    output result_ready,
    output error_valid, error_data,
    input  error_ready,
    input  propagate_valid, propagate_data,
    output propagate_ready
  );

  modport slave (
    input  train,
    input  argument_valid, argument_data,
    output argument_ready,
    output result_valid, result_data,
    input  result_ready,
    input  error_valid, error_data,
    output error_ready,
    output propagate_valid, propagate_data,
    input  propagate_ready
  );
endinterface

// File: rtl/perceptron_trainer.sv
// Drives one perceptron through up to `epochs` training passes over S stored samples,
// then one evaluation pass; reports completed passes and the last pass's mistake count.
module perceptron_trainer #(
  parameter  int N  = 2,
  parameter  int W  = 8,
  parameter  int S  = 4,
  localparam int AW = (S > 1) ? $clog2(S) : 1,
  localparam int CW = $clog2(S + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic [AW-1:0]       load_addr,
  input  logic [N-1:0][W-1:0] load_argument,
  input  logic [W-1:0]        load_target,
  input  logic                start,
  input  logic [7:0]          epochs,
  output logic                busy,
  output logic                done,
  output logic [7:0]          epoch,
  output logic [CW-1:0]       mistakes,
  perceptron_trainer_if.master pif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG,
    S_RES,
    S_ERR,
    S_PRP,
    S_NEXT
  } state_t;

  state_t         state_reg, state_next;
  logic [AW-1:0]  idx_reg, idx_next;
  logic [7:0]     epoch_reg, epoch_next;
  logic [CW-1:0]  count_reg, count_next;
  logic [CW-1:0]  mistakes_reg, mistakes_next;
  logic           train_reg, train_next;
  logic [7:0]     limit_reg, limit_next;
  logic [2*W-1:0] err_reg, err_next;
  logic           done_reg, done_next;
  logic [W:0]     diff;

  logic           load_fire;
  logic [AW-1:0]  rd_addr;
  logic [W-1:0]   wr_lane [N+1];
  logic [W-1:0]   rd_lane [N+1];
  logic           propagate_unused;

  assign load_fire        = load_valid && load_ready;
  assign propagate_unused = ^pif.propagate_data;

  // Address tracks the index the FSM will hold next cycle, so the registered
  // read lands exactly as ARG begins.
  assign rd_addr = idx_next;

  // One RAM lane per argument element plus one for the target. A write that hits the
  // address being read is forwarded so a load issued with start is seen by the run.
  genvar gi;
  generate
    for (gi = 0; gi <= N; gi++) begin : g_lane
      logic [W-1:0] lane_mem [S];

      if (gi < N) begin : g_arg
        assign wr_lane[gi]           = load_argument[gi];
        assign pif.argument_data[gi] = rd_lane[gi];
      end else begin : g_tgt
        assign wr_lane[gi] = load_target;
      end

      always_ff @(posedge clock) begin
        if (load_fire) begin
          lane_mem[load_addr] <= wr_lane[gi];
        end
        if (load_fire && load_addr == rd_addr) begin
          rd_lane[gi] <= wr_lane[gi];
        end else begin
          rd_lane[gi] <= lane_mem[rd_addr];
        end
      end
    end
  endgenerate

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    epoch_next    = epoch_reg;
    count_next    = count_reg;
    mistakes_next = mistakes_reg;
    train_next    = train_reg;
    limit_next    = limit_reg;
    err_next      = err_reg;
    done_next     = 1'b0;
    diff          = {1'b0, rd_lane[N]} - {1'b0, pif.result_data};

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          limit_next = epochs;
          epoch_next = 8'd0;
          count_next = '0;
          idx_next   = '0;
          train_next = (epochs != 8'd0);
          state_next = S_ARG;
        end
      end
      S_ARG: begin
        if (pif.argument_ready) begin
          state_next = S_RES;
        end
      end
      S_RES: begin
        if (pif.result_valid) begin
          err_next = {{(W-1){diff[W]}}, diff};
          if (diff != '0) begin
            count_next = count_reg + CW'(1);
          end
          state_next = train_reg ? S_ERR : S_NEXT;
        end
      end
      S_ERR: begin
        if (pif.error_ready) begin
          state_next = S_PRP;
        end
      end
      S_PRP: begin
        if (pif.propagate_valid) begin
          state_next = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_reg != AW'(S - 1)) begin
          idx_next   = idx_reg + AW'(1);
          state_next = S_ARG;
        end else begin
          mistakes_next = count_reg;
          count_next    = '0;
          idx_next      = '0;
          if (train_reg) begin
            epoch_next = epoch_reg + 8'd1;
            // Error-free pass or budget exhausted: the next pass is the evaluation.
            if (count_reg == '0 || epoch_reg + 8'd1 == limit_reg) begin
              train_next = 1'b0;
            end
            state_next = S_ARG;
          end else begin
            done_next  = 1'b1;
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= S_IDLE;
      idx_reg      <= '0;
      epoch_reg    <= 8'd0;
      count_reg    <= '0;
      mistakes_reg <= '0;
      train_reg    <= 1'b0;
      limit_reg    <= 8'd0;
      err_reg      <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      epoch_reg    <= epoch_next;
      count_reg    <= count_next;
      mistakes_reg <= mistakes_next;
      train_reg    <= train_next;
      limit_reg    <= limit_next;
      err_reg      <= err_next;
      done_reg     <= done_next;
    end
  end

  assign busy                = (state_reg != S_IDLE);
  assign load_ready          = !busy;
  assign done                = done_reg;
  assign epoch               = epoch_reg;
  assign mistakes            = mistakes_reg;
  assign pif.train           = train_reg;
  assign pif.argument_valid  = (state_reg == S_ARG);
  assign pif.result_ready    = (state_reg == S_RES);
  assign pif.error_valid     = (state_reg == S_ERR);
  assign pif.error_data      = err_reg;
  assign pif.propagate_ready = (state_reg == S_PRP);

endmodule

// File: tb/tb_perceptron_trainer.sv
// Randomized bench: a stub perceptron with stalls answers the trainer; a pass-level
// model predicts every argument/error transfer and each run's epoch/mistakes.
module tb_perceptron_trainer;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int S  = 4;
  localparam int AW = 2;
  localparam int CW = 3;

  typedef logic [N-1:0][W-1:0] arg_t;

  logic                clock;
  logic                reset;
  logic                load_valid;
  logic                load_ready;
  logic [AW-1:0]       load_addr;
  arg_t                load_argument;
  logic [W-1:0]        load_target;
  logic                start;
  logic [7:0]          epochs;
  logic                busy;
  logic                done;
  logic [7:0]          epoch;
  logic [CW-1:0]       mistakes;

  perceptron_trainer_if #(.N(N), .W(W)) pif ();

  perceptron_trainer #(.N(N), .W(W), .S(S)) dut (
    .clock         (clock),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_addr     (load_addr),
    .load_argument (load_argument),
    .load_target   (load_target),
    .start         (start),
    .epochs        (epochs),
    .busy          (busy),
    .done          (done),
    .epoch         (epoch),
    .mistakes      (mistakes),
    .pif           (pif)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  arg_t           model_arg [S];
  logic [W-1:0]   model_tgt [S];
  arg_t           exp_arg_q [$];
  logic [2*W-1:0] exp_err_q [$];
  logic [7:0]     exp_epoch_q [$];
  logic [CW-1:0]  exp_mis_q [$];
  int             tests = 0;
  int             fails = 0;
  int             stub_mode = 0;
  bit             stall_en = 1'b0;
  bit             expect_no_train = 1'b0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  function automatic void fail_now(string name, logic [63:0] got);
    tests++;
    fails++;
    $display("FAIL %s: got %0h with nothing expected", name, got);
  endfunction

  // Stub perceptron response: 0 = always zero, 1 = bitwise AND, 2 = fixed hash.
  function automatic logic [W-1:0] stub_f(arg_t a, int mode);
    logic [W-1:0] hi;
    hi = a[1];
    case (mode)
      0:       return '0;
      1:       return a[0] & a[1];
      default: return a[0] ^ {hi[3:0], hi[7:4]};
    endcase
  endfunction

  function automatic bit go();
    return !stall_en || ($urandom_range(0, 1) == 0);
  endfunction

  // Pass-level reference: the stub never learns, so every pass has the same mistakes.
  task automatic model_run(int e, int mode);
    int cnt;
    int p;
    cnt = 0;
    p = 0;
    for (int i = 0; i < S; i++) begin
      if (model_tgt[i] != stub_f(model_arg[i], mode)) cnt++;
    end
    if (e > 0) begin
      do begin
        for (int i = 0; i < S; i++) begin
          exp_arg_q.push_back(model_arg[i]);
          exp_err_q.push_back(16'(int'(model_tgt[i]) - int'(stub_f(model_arg[i], mode))));
        end
        p++;
      end while (!(cnt == 0 || p == e));
    end
    for (int i = 0; i < S; i++) exp_arg_q.push_back(model_arg[i]);
    exp_epoch_q.push_back(8'(p));
    exp_mis_q.push_back(CW'(cnt));
  endtask

  task automatic flush();
    exp_arg_q.delete();
    exp_err_q.delete();
    exp_epoch_q.delete();
    exp_mis_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    flush();
    reset = 1'b0;
  endtask

  task automatic load_sample(int addr, logic [7:0] x, logic [7:0] y, logic [7:0] t);
    @(negedge clock);
    load_valid       = 1'b1;
    load_addr        = AW'(addr);
    load_argument[1] = x;
    load_argument[0] = y;
    load_target      = t;
    model_arg[addr]  = load_argument;
    model_tgt[addr]  = t;
    @(negedge clock);
    load_valid = 1'b0;
  endtask

  task automatic wait_done();
    int c;
    for (c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!busy && exp_epoch_q.size() == 0) break;
    end
    if (c == 3000) begin
      fail_now("run_timeout", 64'(busy));
      do_reset();
    end
  endtask

  task automatic run(int e, int mode, bit stall);
    stub_mode       = mode;
    stall_en        = stall;
    expect_no_train = (e == 0);
    model_run(e, mode);
    @(negedge clock);
    start  = 1'b1;
    epochs = 8'(e);
    @(negedge clock);
    start = 1'b0;
    wait_done();
  endtask

  // Stub perceptron: random readiness, results/propagates presented after random delay.
  initial begin
    bit           hs_arg, hs_res, hs_err, hs_prp;
    logic [W-1:0] res_q [$];
    int           prp_pending;
    pif.argument_ready  = 1'b0;
    pif.result_valid    = 1'b0;
    pif.result_data     = '0;
    pif.error_ready     = 1'b0;
    pif.propagate_valid = 1'b0;
    pif.propagate_data  = '0;
    prp_pending         = 0;
    forever begin
      @(negedge clock);
      hs_arg = pif.argument_valid && pif.argument_ready;
      hs_res = pif.result_valid && pif.result_ready;
      hs_err = pif.error_valid && pif.error_ready;
      hs_prp = pif.propagate_valid && pif.propagate_ready;
      if (hs_arg) res_q.push_back(stub_f(pif.argument_data, stub_mode));
      if (hs_err) prp_pending++;
      @(posedge clock);
      #1;
      if (reset) begin
        res_q.delete();
        prp_pending         = 0;
        pif.result_valid    = 1'b0;
        pif.propagate_valid = 1'b0;
        pif.argument_ready  = 1'b0;
        pif.error_ready     = 1'b0;
      end else begin
        if (hs_res) pif.result_valid = 1'b0;
        if (!pif.result_valid && res_q.size() > 0 && go()) begin
          pif.result_valid = 1'b1;
          pif.result_data  = res_q.pop_front();
        end
        if (hs_prp) pif.propagate_valid = 1'b0;
        if (!pif.propagate_valid && prp_pending > 0 && go()) begin
          pif.propagate_valid = 1'b1;
          pif.propagate_data  = {$urandom, $urandom};
          prp_pending--;
        end
        pif.argument_ready = go();
        pif.error_ready    = go();
      end
    end
  end

  // Monitor: pops expectations on every transfer and at each done pulse.
  initial begin
    bit             pa_v, pa_hs, pe_v, pe_hs;
    arg_t           pa_d;
    logic [2*W-1:0] pe_d;
    pa_v = 1'b0; pa_hs = 1'b0; pe_v = 1'b0; pe_hs = 1'b0;
    pa_d = '0;   pe_d = '0;
    forever begin
      @(negedge clock);
      if (pa_v && !pa_hs && pif.argument_valid && !reset)
        check("arg_hold", pif.argument_data, pa_d);
      if (pe_v && !pe_hs && pif.error_valid && !reset)
        check("err_hold", pif.error_data, pe_d);
      pa_v  = pif.argument_valid;
      pa_d  = pif.argument_data;
      pa_hs = pif.argument_valid && pif.argument_ready;
      pe_v  = pif.error_valid;
      pe_d  = pif.error_data;
      pe_hs = pif.error_valid && pif.error_ready;
      if (pa_hs) begin
        if (exp_arg_q.size() == 0) fail_now("arg_extra", pif.argument_data);
        else check("arg_data", pif.argument_data, exp_arg_q.pop_front());
      end
      if (pe_hs) begin
        if (exp_err_q.size() == 0) fail_now("err_extra", pif.error_data);
        else check("err_data", pif.error_data, exp_err_q.pop_front());
      end
      if (expect_no_train && busy) check("train_off", pif.train, 0);
      if (done) begin
        if (exp_epoch_q.size() == 0) begin
          fail_now("done_extra", epoch);
        end else begin
          check("epoch", epoch, exp_epoch_q.pop_front());
          check("mistakes", mistakes, exp_mis_q.pop_front());
          check("arg_left", exp_arg_q.size(), 0);
          check("err_left", exp_err_q.size(), 0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got busy=%0d", busy);
    $fatal(1, "watchdog");
  end

  initial begin
    int  found;
    reset         = 1'b1;
    load_valid    = 1'b0;
    load_addr     = '0;
    load_argument = '0;
    load_target   = '0;
    start         = 1'b0;
    epochs        = 8'd0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_epoch", epoch, 0);
    check("rst_mistakes", mistakes, 0);
    check("rst_train", pif.train, 0);
    check("rst_arg_valid", pif.argument_valid, 0);
    check("rst_res_ready", pif.result_ready, 0);
    check("rst_err_valid", pif.error_valid, 0);
    check("rst_prp_ready", pif.propagate_ready, 0);
    check("rst_load_ready", load_ready, 1);
    reset = 1'b0;

    // AND truth table
    load_sample(0, 8'h00, 8'h00, 8'h00);
    load_sample(1, 8'h00, 8'hff, 8'h00);
    load_sample(2, 8'hff, 8'h00, 8'h00);
    load_sample(3, 8'hff, 8'hff, 8'hff);

    run(10, 1, 1'b1);   // perfect responder: early stop after one pass
    run(0, 0, 1'b1);    // eval only, all-zero results: one mistake
    run(10, 2, 1'b1);   // non-learning responder: full epoch budget
    run(3, 0, 1'b0);

    // Reset while an error transfer is pending in the second pass
    stub_mode = 0; stall_en = 1'b1; expect_no_train = 1'b0;
    model_run(3, 0);
    @(negedge clock); start = 1'b1; epochs = 8'd3;
    @(negedge clock); start = 1'b0;
    found = 0;
    for (int c = 0; c < 3000; c++) begin
      if (pif.error_valid && epoch == 8'd1) begin
        found = 1;
        break;
      end
      @(negedge clock);
    end
    check("err_state_reached", found, 1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("midrst_err_valid", pif.error_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_epoch", epoch, 0);
    @(negedge clock);
    flush();
    reset = 1'b0;
    run(3, 0, 1'b1);

    // Start and load while busy must be ignored
    stub_mode = 2; stall_en = 1'b1; expect_no_train = 1'b0;
    model_run(4, 2);
    @(negedge clock); start = 1'b1; epochs = 8'd4;
    @(negedge clock); start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      if (!busy) break;
      check("load_ready_busy", load_ready, 0);
      start         = 1'($urandom_range(0, 1));
      load_valid    = 1'($urandom_range(0, 1));
      load_addr     = AW'($urandom_range(0, S - 1));
      load_argument = {$urandom}[2*W-1:0];
      load_target   = 8'($urandom);
    end
    start      = 1'b0;
    load_valid = 1'b0;
    wait_done();
    run(0, 2, 1'b0);

    // Load and start in the same cycle: run must see the new sample
    stub_mode = 2; stall_en = 1'b0; expect_no_train = 1'b1;
    @(negedge clock);
    load_valid       = 1'b1;
    load_addr        = '0;
    load_argument[1] = 8'h5a;
    load_argument[0] = 8'hc3;
    load_target      = 8'h17;
    model_arg[0]     = load_argument;
    model_tgt[0]     = load_target;
    start            = 1'b1;
    epochs           = 8'd0;
    model_run(0, 2);
    @(negedge clock);
    load_valid = 1'b0;
    start      = 1'b0;
    wait_done();

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < S; i++)
        load_sample(i, 8'($urandom), 8'($urandom), 8'($urandom));
      run($urandom_range(0, 4), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
